// File: rtl/hamming_pkg.sv
// Shared Hamming(15,11) constants, codeword position maps and FSM encoding.
// Used by both the encoder and decoder datapaths.
package hamming_pkg;

    localparam int N     = 15;
    localparam int K     = 11;
    localparam int SYN_W = 4;

    // Positions are 1-based; entry i of each map is packed at [i*SYN_W +: SYN_W].
    localparam logic [4*SYN_W-1:0] PARITY_POS = {4'd8, 4'd4, 4'd2, 4'd1};
    localparam logic [K*SYN_W-1:0] DATA_POS   = {4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10,
                                                 4'd9, 4'd7, 4'd6, 4'd5, 4'd3};

    localparam logic [3:0] CNT_LAST = 4'(N - 1);
    localparam logic [3:0] IDX_LAST = 4'(K - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CORRECT = 2'd1,
        ST_SHIFT   = 2'd2
    } state_t;

    // Syndrome bit i covers every position sharing a set bit with parity position i.
    function automatic logic [SYN_W-1:0] calc_syndrome(input logic [N-1:0] cw);
        logic [SYN_W-1:0] s;
        s = '0;
        for (int p = 1; p <= N; p++) begin
            for (int i = 0; i < SYN_W; i++) begin
                if (cw[p-1] && ((4'(p) & PARITY_POS[i*SYN_W +: SYN_W]) != 4'd0)) begin
                    s[i] = ~s[i];
                end
            end
        end
        return s;
    endfunction

    function automatic logic [K-1:0] extract_data(input logic [N-1:0] cw);
        logic [K-1:0] d;
        d = '0;
        for (int i = 0; i < K; i++) begin
            d[i] = cw[int'(DATA_POS[i*SYN_W +: SYN_W]) - 1];
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_syndrome_correct.sv
// Combinational syndrome computation and single-bit correction of one codeword.
// Bit p-1 of cw_i holds codeword position p.
module hamming_syndrome_correct
    import hamming_pkg::*;
(
    input  logic [N-1:0]     cw_i,
    output logic [SYN_W-1:0] syn_o,
    output logic [K-1:0]     data_o
);

    logic [N-1:0] fixed;

    assign syn_o = calc_syndrome(cw_i);

    // Every non-zero syndrome names a real position, so it is always flipped.
    always_comb begin
        fixed = cw_i;
        if (syn_o != '0) begin
            fixed[syn_o - 4'd1] = ~cw_i[syn_o - 4'd1];
        end
    end

    assign data_o = extract_data(fixed);

endmodule

// File: rtl/hamming_decoder_datapath.sv
// Serial Hamming(15,11) decoder: frames 15-bit codewords, corrects single errors, emits 11 data bits MSB first.
// Optional HAMMING_DEC_STATS_EN adds saturating word / corrected-word counters.
module hamming_decoder_datapath
    import hamming_pkg::*;
(
    input  logic             CLK_IN,
    input  logic             REST_N,
    input  logic             DEVICE_EN,
    input  logic             SERIAL_IN,
    input  logic             IN_VALID,
    output logic             SERIAL_OUT,
    output logic             OUT_VALID,
    output logic             WORD_START,
    output logic             ERR_FLAG,
    output logic [SYN_W-1:0] SYNDROME
`ifdef HAMMING_DEC_STATS_EN
    ,
    output logic [15:0]      WORD_CNT,
    output logic [15:0]      CORR_CNT
`endif
);

    logic [3:0]       cnt_q, cnt_d;
    logic [N-1:0]     sr_q, sr_d;
    logic             word_done;

    state_t           state_q, state_d;
    logic             load_word;
    logic             shift_active;

    logic [K-1:0]     buf_q, buf_d;
    logic [3:0]       idx_q, idx_d;
    logic             sout_q, sout_d;
    logic             ovld_q, ovld_d;
    logic             wstart_q, wstart_d;
    logic             err_q, err_d;
    logic [SYN_W-1:0] syn_q, syn_d;

    logic [SYN_W-1:0] syn_w;
    logic [K-1:0]     data_w;

    hamming_syndrome_correct u_syn_corr (
        .cw_i   (sr_q),
        .syn_o  (syn_w),
        .data_o (data_w)
    );

    // The shift register keeps sliding after a word completes; CORRECT reads it
    // in the following cycle, before the next word's bits can disturb it.
    always_comb begin
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        word_done = 1'b0;
        if (!DEVICE_EN) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (IN_VALID) begin
            sr_d = {sr_q[N-2:0], SERIAL_IN};
            if (cnt_q == CNT_LAST) begin
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK_IN or negedge REST_N) begin
        if (!REST_N) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

    always_ff @(posedge CLK_IN or negedge REST_N) begin
        if (!REST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Word spacing of 15 input cycles exceeds the 12-cycle CORRECT+SHIFT
    // occupancy, so word_done is only ever seen in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (word_done) state_d = ST_CORRECT;
            ST_CORRECT: state_d = ST_SHIFT;
            ST_SHIFT:   if (idx_q == IDX_LAST) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (!DEVICE_EN) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        load_word    = (state_q == ST_CORRECT);
        shift_active = (state_q == ST_SHIFT);
    end

    always_comb begin
        buf_d    = buf_q;
        idx_d    = idx_q;
        sout_d   = 1'b0;
        ovld_d   = 1'b0;
        wstart_d = 1'b0;
        err_d    = err_q;
        syn_d    = syn_q;
        if (!DEVICE_EN) begin
            buf_d = '0;
            idx_d = '0;
            err_d = 1'b0;
            syn_d = '0;
        end else if (load_word) begin
            buf_d = data_w;
            idx_d = '0;
            err_d = (syn_w != '0);
            syn_d = syn_w;
        end else if (shift_active) begin
            sout_d   = buf_q[K-1];
            ovld_d   = 1'b1;
            wstart_d = (idx_q == 4'd0);
            buf_d    = {buf_q[K-2:0], 1'b0};
            idx_d    = idx_q + 4'd1;
        end
    end

    always_ff @(posedge CLK_IN or negedge REST_N) begin
        if (!REST_N) begin
            buf_q    <= '0;
            idx_q    <= '0;
            sout_q   <= 1'b0;
            ovld_q   <= 1'b0;
            wstart_q <= 1'b0;
            err_q    <= 1'b0;
            syn_q    <= '0;
        end else begin
            buf_q    <= buf_d;
            idx_q    <= idx_d;
            sout_q   <= sout_d;
            ovld_q   <= ovld_d;
            wstart_q <= wstart_d;
            err_q    <= err_d;
            syn_q    <= syn_d;
        end
    end

    assign SERIAL_OUT = sout_q;
    assign OUT_VALID  = ovld_q;
    assign WORD_START = wstart_q;
    assign ERR_FLAG   = err_q;
    assign SYNDROME   = syn_q;

`ifdef HAMMING_DEC_STATS_EN
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] corr_cnt_q, corr_cnt_d;

    // Counters survive DEVICE_EN flushes; only REST_N clears them.
    always_comb begin
        word_cnt_d = word_cnt_q;
        corr_cnt_d = corr_cnt_q;
        if (load_word && DEVICE_EN) begin
            if (word_cnt_q != 16'hFFFF) word_cnt_d = word_cnt_q + 16'd1;
            if ((syn_w != '0) && (corr_cnt_q != 16'hFFFF)) corr_cnt_d = corr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK_IN or negedge REST_N) begin
        if (!REST_N) begin
            word_cnt_q <= '0;
            corr_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            corr_cnt_q <= corr_cnt_d;
        end
    end

    assign WORD_CNT = word_cnt_q;
    assign CORR_CNT = corr_cnt_q;
`endif

endmodule

// File: tb/tb_hamming_decoder_datapath.sv
// Scoreboard bench for hamming_decoder_datapath: directed and random codewords
// against a plain-arithmetic Hamming(15,11) reference encoder.
module tb_hamming_decoder_datapath;

    logic       CLK_IN;
    logic       REST_N;
    logic       DEVICE_EN;
    logic       SERIAL_IN;
    logic       IN_VALID;
    logic       SERIAL_OUT;
    logic       OUT_VALID;
    logic       WORD_START;
    logic       ERR_FLAG;
    logic [3:0] SYNDROME;
`ifdef HAMMING_DEC_STATS_EN
    logic [15:0] WORD_CNT;
    logic [15:0] CORR_CNT;
`endif

    hamming_decoder_datapath dut (
        .CLK_IN     (CLK_IN),
        .REST_N     (REST_N),
        .DEVICE_EN  (DEVICE_EN),
        .SERIAL_IN  (SERIAL_IN),
        .IN_VALID   (IN_VALID),
        .SERIAL_OUT (SERIAL_OUT),
        .OUT_VALID  (OUT_VALID),
        .WORD_START (WORD_START),
        .ERR_FLAG   (ERR_FLAG),
        .SYNDROME   (SYNDROME)
`ifdef HAMMING_DEC_STATS_EN
        ,
        .WORD_CNT   (WORD_CNT),
        .CORR_CNT   (CORR_CNT)
`endif
    );

    typedef struct {
        logic [10:0] data;
        logic [3:0]  syn;
        int          start;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   nb = 0;
    int   edge_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    int   model_words = 0;
    int   model_corr = 0;

    initial CLK_IN = 1'b0;
    always #5 CLK_IN = ~CLK_IN;
    always @(posedge CLK_IN) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Reference encoder: data fills the non-power-of-two positions in order,
    // then each parity bit makes its syndrome bit zero.
    function automatic logic [15:1] encode(input logic [10:0] d);
        logic [15:1] c;
        logic [3:0]  s;
        int          j;
        c = '0;
        j = 0;
        for (int p = 1; p <= 15; p++) begin
            if (p != 1 && p != 2 && p != 4 && p != 8) begin
                c[p] = d[j];
                j++;
            end
        end
        s = '0;
        for (int p = 1; p <= 15; p++) if (c[p]) s = s ^ 4'(p);
        c[1] = s[0];
        c[2] = s[1];
        c[4] = s[2];
        c[8] = s[3];
        return c;
    endfunction

    task automatic idle_cycles(input int n);
        IN_VALID = 1'b0;
        repeat (n) begin
            @(posedge CLK_IN);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        SERIAL_IN = b;
        IN_VALID  = 1'b1;
        @(posedge CLK_IN);
        #1;
        IN_VALID  = 1'b0;
    endtask

    task automatic send_word(input logic [15:1] cw, input logic [10:0] d, input logic [3:0] syn,
                             input int gap_at, input int gap_len, input bit rnd_gaps,
                             output int first, output int k);
        exp_t e;
        first = 0;
        for (int i = 0; i < 15; i++) begin
            if (i == gap_at) idle_cycles(gap_len);
            if (rnd_gaps && i != 0 && $urandom_range(0, 4) == 0) idle_cycles($urandom_range(1, 3));
            send_bit(cw[15 - i]);
            if (i == 0) first = edge_cnt;
        end
        k = edge_cnt;
        e.data  = d;
        e.syn   = syn;
        e.start = k + 2;
        sb_q.push_back(e);
        model_words++;
        if (syn != 4'd0) model_corr++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || nb != 0) && n < 300) begin
            @(posedge CLK_IN);
            #1;
            n++;
        end
        chk("drain_within_budget", int'(n < 300), 1);
    endtask

    // Monitor: pops the expectation at WORD_START and checks every output bit.
    always @(negedge CLK_IN) begin
        if (!REST_N) begin
            nb = 0;
        end else if (OUT_VALID) begin
            if (nb == 0) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: output burst at edge %0d, expected none", edge_cnt);
                    cur.data  = '0;
                    cur.syn   = '0;
                    cur.start = edge_cnt;
                end else begin
                    cur = sb_q.pop_front();
                end
                chk("word_start_cycle", edge_cnt, cur.start);
            end
            chk("out_bit{ws,err,syn,dat}",
                {25'd0, WORD_START, ERR_FLAG, SYNDROME, SERIAL_OUT},
                {25'd0, (nb == 0), (cur.syn != 4'd0), cur.syn, cur.data[10 - nb]});
            nb++;
            if (nb == 11) nb = 0;
        end else if (nb != 0) begin
            checks++;
            errors++;
            $display("FAIL burst_gap: OUT_VALID low after %0d of 11 bits", nb);
            nb = 0;
        end
    end

    initial begin
        logic [15:1] cw;
        logic [15:1] base;
        logic [10:0] d;
        int          flip;
        int          f0, k0, f1, k1;

        REST_N    = 1'b0;
        DEVICE_EN = 1'b0;
        SERIAL_IN = 1'b0;
        IN_VALID  = 1'b0;
        repeat (3) @(posedge CLK_IN);
        #1;
        chk("reset_outputs", {27'd0, SERIAL_OUT, OUT_VALID, WORD_START, ERR_FLAG, |SYNDROME}, 0);
        chk("reset_syndrome", SYNDROME, 0);
        REST_N    = 1'b1;
        DEVICE_EN = 1'b1;
        idle_cycles(2);

        base = 15'h75A7;
        send_word(base, 11'h755, 4'd0, -1, 0, 1'b0, f0, k0);
        cw = base; cw[6] = ~cw[6];
        send_word(cw, 11'h755, 4'd6, -1, 0, 1'b0, f0, k0);
        cw = base; cw[1] = ~cw[1];
        send_word(cw, 11'h755, 4'd1, -1, 0, 1'b0, f0, k0);
        send_word(15'h0000, 11'h000, 4'd0, -1, 0, 1'b0, f0, k0);
        send_word(15'h7FFF, 11'h7FF, 4'd0, -1, 0, 1'b0, f1, k1);
        chk("back_to_back_spacing", k1 - k0, 15);
        drain();

        send_word(base, 11'h755, 4'd0, 7, 20, 1'b0, f0, k0);
        chk("gap20_word_span", k0 - f0, 14 + 20);
        drain();

        for (int i = 0; i < 7; i++) send_bit(base[15 - i]);
        DEVICE_EN = 1'b0;
        idle_cycles(2);
        DEVICE_EN = 1'b1;
        send_word(base, 11'h755, 4'd0, -1, 0, 1'b0, f0, k0);
        drain();

        for (int w = 0; w < 30; w++) begin
            d    = 11'($urandom_range(0, 2047));
            flip = $urandom_range(0, 15);
            cw   = encode(d);
            if (flip != 0) cw[flip] = ~cw[flip];
            send_word(cw, d, 4'(flip), -1, 0, 1'b1, f0, k0);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 6));
        end
        drain();

`ifdef HAMMING_DEC_STATS_EN
        chk("word_cnt", WORD_CNT, model_words);
        chk("corr_cnt", CORR_CNT, model_corr);
`endif

        cw = base; cw[11] = ~cw[11];
        send_word(cw, 11'h755, 4'd11, -1, 0, 1'b0, f0, k0);
        repeat (6) begin
            @(posedge CLK_IN);
            #1;
        end
        REST_N = 1'b0;
        model_words = 0;
        model_corr  = 0;
        #1;
        chk("rst_mid_shift_ctrl", {29'd0, SERIAL_OUT, OUT_VALID, WORD_START}, 0);
        chk("rst_mid_shift_err", ERR_FLAG, 0);
        chk("rst_mid_shift_syn", SYNDROME, 0);
        repeat (2) @(posedge CLK_IN);
        #1;
        REST_N = 1'b1;
        idle_cycles(1);

        d = 11'h2A5;
        cw = encode(d);
        cw[9] = ~cw[9];
        send_word(cw, d, 4'd9, -1, 0, 1'b0, f0, k0);
        send_word(encode(11'h1C3), 11'h1C3, 4'd0, -1, 0, 1'b0, f0, k0);
        send_word(encode(11'h64E), 11'h64E, 4'd0, -1, 0, 1'b0, f0, k0);
        drain();
        idle_cycles(3);
        chk("idle_after_drain", OUT_VALID, 0);
        chk("status_hold_err", ERR_FLAG, 0);
`ifdef HAMMING_DEC_STATS_EN
        chk("word_cnt_after_reset", WORD_CNT, 3);
        chk("corr_cnt_after_reset", CORR_CNT, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
